// File: rtl/keyboard_common.sv
// Shared types and scancode constants for the PS/2 keyboard event path.
package keyboard_common;

  typedef logic [7:0] byte_t;

  typedef struct packed {
    logic  brk;
    logic  extended;
    byte_t scancode;
  } kbd_event_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } dec_state_t;

  localparam byte_t SC_EXT = 8'hE0;
  localparam byte_t SC_BRK = 8'hF0;

  // Controller replies and error codes, never part of a key sequence.
  localparam int    NUM_NON_KEY = 6;
  localparam byte_t NON_KEY_CODES [NUM_NON_KEY] = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

endpackage

// File: rtl/kbd_event_fifo.sv
// First-word-fall-through event FIFO; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
import keyboard_common::*;

module kbd_event_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   push_i,
  input  kbd_event_t             data_i,
  input  logic                   pop_i,
  output kbd_event_t             data_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  kbd_event_t     mem_reg [DEPTH];
  logic [AW-1:0]  wr_ptr_reg;
  logic [AW-1:0]  rd_ptr_reg;
  logic [AW:0]    count_reg;
  logic           do_pop;
  logic           do_push;

  assign empty_o = (count_reg == '0);
  assign full_o  = (count_reg == FULL_COUNT);
  assign count_o = count_reg;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = empty_o ? '0 : mem_reg[rd_ptr_reg];

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= data_i;
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      if (do_push && !do_pop) begin
        count_reg <= count_reg + (AW + 1)'(1);
      end else if (do_pop && !do_push) begin
        count_reg <= count_reg - (AW + 1)'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_keyboard_buffered.sv
// PS/2 scancode set 2 decoder with typematic-repeat filter feeding an event FIFO.
import keyboard_common::*;

module ps2_keyboard_buffered #(
  parameter int DEPTH         = 8,
  parameter bit FILTER_REPEAT = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  byte_t                  data_i,
  input  logic                   valid_i,
  output kbd_event_t             event_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   overflow_o
);

  dec_state_t state_reg;
  kbd_event_t pend_event_reg;
  logic       pend_valid_reg;
  logic       lm_valid_reg;
  logic       lm_ext_reg;
  byte_t      lm_code_reg;
  logic       overflow_reg;

  logic [NUM_NON_KEY-1:0] non_key_hit;
  logic       is_non_key;
  logic       prefix_ext;
  logic       prefix_brk;
  kbd_event_t cand_event;
  logic       lm_match;
  logic       repeat_drop;
  logic       fifo_empty;
  logic       fifo_full;

  generate
    for (genvar gi = 0; gi < NUM_NON_KEY; gi++) begin : g_non_key
      assign non_key_hit[gi] = (data_i == NON_KEY_CODES[gi]);
    end
  endgenerate

  assign is_non_key = |non_key_hit;
  // E0 only acts as a prefix before any F0; F0 is absorbed until E0 F0 is complete.
  assign prefix_ext = (data_i == SC_EXT) && (state_reg == IDLE || state_reg == EXT);
  assign prefix_brk = (data_i == SC_BRK) && (state_reg != EXT_BRK);

  assign cand_event.brk      = (state_reg == BRK) || (state_reg == EXT_BRK);
  assign cand_event.extended = (state_reg == EXT) || (state_reg == EXT_BRK);
  assign cand_event.scancode = data_i;

  assign lm_match    = lm_valid_reg && (lm_ext_reg == cand_event.extended) &&
                       (lm_code_reg == data_i);
  assign repeat_drop = FILTER_REPEAT && !cand_event.brk && lm_match;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_reg      <= IDLE;
      pend_event_reg <= '0;
      pend_valid_reg <= 1'b0;
      lm_valid_reg   <= 1'b0;
      lm_ext_reg     <= 1'b0;
      lm_code_reg    <= '0;
    end else begin
      pend_valid_reg <= 1'b0;
      if (valid_i) begin
        if (is_non_key) begin
          state_reg <= IDLE;
        end else if (prefix_ext) begin
          state_reg <= EXT;
        end else if (prefix_brk) begin
          state_reg <= (state_reg == EXT) ? EXT_BRK : BRK;
        end else begin
          state_reg <= IDLE;
          if (!repeat_drop) begin
            pend_valid_reg <= 1'b1;
            pend_event_reg <= cand_event;
          end
          if (!cand_event.brk && !repeat_drop) begin
            lm_valid_reg <= 1'b1;
            lm_ext_reg   <= cand_event.extended;
            lm_code_reg  <= data_i;
          end else if (cand_event.brk && lm_match) begin
            lm_valid_reg <= 1'b0;
          end
        end
      end
    end
  end

  // A full FIFO can only take the pending event if the head leaves this cycle.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      overflow_reg <= 1'b0;
    end else if (pend_valid_reg && fifo_full && !ready_i) begin
      overflow_reg <= 1'b1;
    end
  end

  kbd_event_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (pend_valid_reg),
    .data_i  (pend_event_reg),
    .pop_i   (ready_i),
    .data_o  (event_o),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (count_o)
  );

  assign valid_o    = !fifo_empty;
  assign overflow_o = overflow_reg;

endmodule

// File: tb/tb_ps2_keyboard_buffered.sv
// Two instances (filtering depth 4, unfiltered depth 8) share one byte stream;
// a byte-level reference model feeds per-instance scoreboards.
import keyboard_common::*;

module tb_ps2_keyboard_buffered;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  byte_t      dat = '0;
  logic       vld = 1'b0;
  logic       rdy [2];
  int         rmode = 1;

  kbd_event_t ev_o  [2];
  logic       vo    [2];
  logic [3:0] cnt_o [2];
  logic       ovf_o [2];
  logic [2:0] cnt_a;
  logic [3:0] cnt_b;

  int checks = 0;
  int failures = 0;

  // Reference model state
  kbd_event_t exp_q [2][$];
  int         mcount [2];
  logic       m_ovf [2];
  logic       pend_v [2];
  kbd_event_t pend_e [2];
  logic       pfx_ext [2];
  logic       pfx_brk [2];
  logic       lm_v [2];
  kbd_event_t lm_e [2];
  logic       in_reset [2];
  int         depth_of [2] = '{4, 8};
  logic       filter_of [2] = '{1'b1, 1'b0};

  always #5 clk = ~clk;

  ps2_keyboard_buffered #(.DEPTH(4), .FILTER_REPEAT(1'b1)) dut_a (
    .clk_i(clk), .reset_i(rstn), .data_i(dat), .valid_i(vld),
    .event_o(ev_o[0]), .valid_o(vo[0]), .ready_i(rdy[0]),
    .count_o(cnt_a), .overflow_o(ovf_o[0]));

  ps2_keyboard_buffered #(.DEPTH(8), .FILTER_REPEAT(1'b0)) dut_b (
    .clk_i(clk), .reset_i(rstn), .data_i(dat), .valid_i(vld),
    .event_o(ev_o[1]), .valid_o(vo[1]), .ready_i(rdy[1]),
    .count_o(cnt_b), .overflow_o(ovf_o[1]));

  assign cnt_o[0] = {1'b0, cnt_a};
  assign cnt_o[1] = cnt_b;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%0h required=%0h t=%0t", name, k, act, exp, $time);
    end
  endtask

  function automatic logic is_non_key_byte(input byte_t b);
    return b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
  endfunction

  // Byte-level protocol: prefixes accumulate, a key byte completes an event.
  task automatic model_byte(input int k, input byte_t b);
    kbd_event_t ev;
    if (is_non_key_byte(b)) begin
      pfx_ext[k] = 1'b0;
      pfx_brk[k] = 1'b0;
    end else if (b == 8'hE0 && !pfx_brk[k]) begin
      pfx_ext[k] = 1'b1;
    end else if (b == 8'hF0 && !(pfx_ext[k] && pfx_brk[k])) begin
      pfx_brk[k] = 1'b1;
    end else begin
      ev.brk = pfx_brk[k];
      ev.extended = pfx_ext[k];
      ev.scancode = b;
      pfx_ext[k] = 1'b0;
      pfx_brk[k] = 1'b0;
      if (!ev.brk) begin
        if (!(filter_of[k] && lm_v[k] && lm_e[k] == ev)) begin
          pend_v[k] = 1'b1;
          pend_e[k] = ev;
          lm_v[k] = 1'b1;
          lm_e[k] = ev;
        end
      end else begin
        pend_v[k] = 1'b1;
        pend_e[k] = ev;
        if (lm_v[k] && lm_e[k].extended == ev.extended && lm_e[k].scancode == ev.scancode)
          lm_v[k] = 1'b0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rstn) begin
        in_reset[k] = 1'b1;
        exp_q[k].delete();
        mcount[k] = 0;
        m_ovf[k] = 1'b0;
        pend_v[k] = 1'b0;
        pfx_ext[k] = 1'b0;
        pfx_brk[k] = 1'b0;
        lm_v[k] = 1'b0;
      end else begin
        logic pop_m;
        in_reset[k] = 1'b0;
        pop_m = (mcount[k] > 0) && rdy[k];
        if (pend_v[k]) begin
          if (mcount[k] < depth_of[k] || pop_m) begin
            exp_q[k].push_back(pend_e[k]);
            mcount[k]++;
          end else begin
            m_ovf[k] = 1'b1;
          end
        end
        if (pop_m) mcount[k]--;
        pend_v[k] = 1'b0;
        if (vld) model_byte(k, dat);
      end
    end
  end

  // Monitor: occupancy and flags every cycle, event contents on each handshake.
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("count_o", k, 32'(cnt_o[k]), 32'(mcount[k]));
      chk("valid_o", k, 32'(vo[k]), 32'(mcount[k] > 0));
      chk("overflow_o", k, 32'(ovf_o[k]), 32'(m_ovf[k]));
      if (in_reset[k]) chk("event_o_reset", k, 32'(ev_o[k]), 32'h0);
      if (vo[k] && rdy[k]) begin
        if (exp_q[k].size() == 0) begin
          chk("unexpected_event", k, 32'(ev_o[k]), 32'hFFFFFFFF);
        end else begin
          kbd_event_t e;
          e = exp_q[k].pop_front();
          chk("event_o", k, 32'(ev_o[k]), 32'(e));
          $display("xfer dut%0d brk=%0b ext=%0b code=%02h", k, ev_o[k].brk, ev_o[k].extended, ev_o[k].scancode);
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (rmode)
      0: begin
        rdy[0] = ($urandom_range(0, 3) != 0);
        rdy[1] = ($urandom_range(0, 3) != 0);
      end
      1: begin rdy[0] = 1'b0; rdy[1] = 1'b0; end
      2: begin rdy[0] = 1'b1; rdy[1] = 1'b1; end
      default: ;
    endcase
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input byte_t b, input int gap);
    dat = b;
    vld = 1'b1;
    idle(1);
    vld = 1'b0;
    idle(gap);
  endtask

  task automatic pulse_reset();
    rstn = 1'b0;
    idle(1);
    rstn = 1'b1;
  endtask

  function automatic byte_t rand_byte();
    byte_t keys [4] = '{8'h1C, 8'h75, 8'h2D, 8'h6B};
    byte_t nk [6] = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
    int p;
    p = $urandom_range(0, 11);
    if (p < 2) return 8'hE0;
    if (p < 4) return 8'hF0;
    if (p == 4) return nk[$urandom_range(0, 5)];
    if (p < 9) return keys[$urandom_range(0, 3)];
    return byte_t'($urandom_range(0, 255));
  endfunction

  initial begin
    byte_t seq_basic [16] = '{8'h1C, 8'hF0, 8'h1C, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75,
                              8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'hAA, 8'hFA, 8'hE0};
    byte_t ovf_set [5] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    byte_t fill_set [4] = '{8'h16, 8'h1E, 8'h26, 8'h25};
    rdy[0] = 1'b0;
    rdy[1] = 1'b0;
    idle(3);
    rstn = 1'b1;
    rmode = 2;

    // Back-to-back directed sequences, then the FE/2D tail
    foreach (seq_basic[i]) send(seq_basic[i], 0);
    send(8'hFE, 0);
    send(8'h2D, 2);
    foreach (seq_basic[i]) send(seq_basic[i], 1);
    idle(4);

    // Prefix abandoned by reset; first byte lands on the first edge after release
    send(8'hE0, 0);
    pulse_reset();
    send(8'h1C, 3);

    // Overflow: consumer stalled, more makes than the small FIFO holds
    rmode = 1;
    idle(1);
    foreach (ovf_set[i]) send(ovf_set[i], 0);
    idle(3);
    rmode = 2;
    idle(12);

    // Full FIFO with simultaneous push and pop
    pulse_reset();
    rmode = 1;
    idle(1);
    foreach (fill_set[i]) send(fill_set[i], 0);
    idle(2);
    rmode = 3;
    dat = 8'h2E;
    vld = 1'b1;
    idle(1);
    vld = 1'b0;
    rdy[0] = 1'b1;
    rdy[1] = 1'b1;
    idle(1);
    rdy[0] = 1'b0;
    rdy[1] = 1'b0;
    rmode = 1;
    idle(2);
    rmode = 2;
    idle(12);

    // Randomised traffic with random backpressure
    rmode = 0;
    for (int i = 0; i < 600; i++) begin
      if (i == 300) pulse_reset();
      send(rand_byte(), $urandom_range(0, 2));
    end

    rmode = 2;
    idle(30);
    for (int k = 0; k < 2; k++) chk("drained", k, 32'(exp_q[k].size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_buffered.md
PS2_KEYBOARD_BUFFERED -- requirements
Module: ps2_keyboard_buffered

Interface
REQ-001 SHALL have parameter DEPTH, default 8: event FIFO depth; power of two, >= 2.
REQ-002 SHALL have parameter FILTER_REPEAT, default 1: 1 = drop typematic repeat makes, 0 = pass every make.
REQ-003 SHALL have port clk_i  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset_i  input  1  synchronous, active-low reset.
REQ-005 SHALL have port data_i  input  8 (byte_t)  received PS/2 byte.
REQ-006 SHALL have port valid_i  input  1  data_i valid for exactly this cycle; no backpressure.
REQ-007 SHALL have port event_o  output  kbd_event_t  FIFO head: {brk, extended, scancode[7:0]}.
REQ-008 SHALL have port valid_o  output  1  FIFO non-empty, event_o valid.
REQ-009 SHALL have port ready_i  input  1  consumer accepts head; pop when valid_o && ready_i.
REQ-010 SHALL have port count_o  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-011 SHALL have port overflow_o  output  1  sticky: an event was dropped because FIFO full.

Function
REQ-012 SHALL decode with FSM states IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
REQ-013 SHALL transition IDLE->EXT on E0, IDLE->BRK on F0, EXT->EXT_BRK on F0, EXT->EXT on E0, BRK->BRK on F0.
REQ-014 SHALL, on any other byte in state S, form event {brk=(S in BRK/EXT_BRK), extended=(S in EXT/EXT_BRK), scancode=byte} and return to IDLE.
REQ-015 SHALL discard non-key bytes AA, FA, FE, EE, 00, FF in any state, producing no event and returning to IDLE.
REQ-016 SHALL ignore data_i when valid_i is low; FSM holds state indefinitely between bytes.
REQ-017 SHALL, with FILTER_REPEAT=1, hold last_make {valid, extended, scancode}; drop a make equal to last_make while valid.
REQ-018 SHALL update last_make on every non-dropped make; clear last_make.valid on a break matching it; a non-matching break leaves it.
REQ-019 SHALL register decoded events one cycle before FIFO write: final byte sampled at edge N, event written at edge N+1, valid_o high after edge N+1 when FIFO was empty.
REQ-020 SHALL implement FIFO as first-word-fall-through: event_o valid whenever valid_o high, stable until popped.
REQ-021 SHALL, on simultaneous write and pop when full, accept both; count unchanged; overflow_o unchanged.
REQ-022 SHALL, on write when full without pop, drop new event, keep contents, set overflow_o.
REQ-023 SHALL ignore ready_i when empty; pointers wrap modulo DEPTH.
REQ-024 SHALL keep overflow_o set until reset.

Reset
REQ-025 SHALL, while reset_i low at a rising edge: FSM=IDLE, FIFO empty, valid_o=0, count_o=0, overflow_o=0, event_o=0, last_make.valid=0, pending event register cleared.
REQ-026 SHALL abandon mid-sequence prefixes (e.g. E0 received, reset, then 1C yields non-extended make 1C).
REQ-027 SHALL accept valid_i on the first edge after reset_i returns high.

Structure
REQ-028 SHALL define kbd_event_t and scancode constants (E0, F0, non-key codes) in package keyboard_common.
REQ-029 SHALL instantiate one sub-module kbd_event_fifo (parameter DEPTH, FWFT, push/pop/full/count); decode and filter in top module.

Verification
REQ-030 Bytes 1C, F0, 1C -> make{0,0,1C} then break{1,0,1C}; valid_o one cycle after each final-byte edge.
REQ-031 Bytes E0 75, E0 F0 75 -> make{0,1,75}, break{1,1,75}; no events for E0/F0 bytes.
REQ-032 FILTER_REPEAT=1, bytes 1C x3, F0 1C -> exactly one make{0,0,1C} then break; FILTER_REPEAT=0 -> three makes then break.
REQ-033 DEPTH=4, ready_i=0, 5 distinct makes -> count_o=4, overflow_o=1, pops yield first 4 in order; full + simultaneous push/pop -> no overflow.
REQ-034 Bytes AA, FA, E0 FE, 2D -> single make{0,0,2D}.
REQ-035 E0 then reset_i low one cycle then 1C -> make{0,0,1C}; all outputs 0 during reset.
